// File: rtl/race_pkg.sv
// race_pkg: shared types and helpers for the race pulse generator.
//   race_state_t  - symbol FSM states
//   RACE_N        - default winner edge count (receiver threshold)
//   RACE_CNT_W    - edge-counter width for RACE_N
//   edge_cnt_w()  - edge-counter width for an arbitrary N
//   bits_for()    - width of a 0..n-1 counter (minimum 1)
//   clamp_period()- raise a period to at least pw+1 cycles
package race_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_TAIL = 2'd2,
        S_GAP  = 2'd3
    } race_state_t;

    function automatic int edge_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RACE_N     = 10;
    localparam int RACE_CNT_W = edge_cnt_w(RACE_N);

    // A period of pw+1 leaves at least one low cycle between pw-wide pulses.
    function automatic logic [31:0] clamp_period(input logic [31:0] p, input int pw);
        logic [31:0] floor_p;
        floor_p = 32'(pw + 1);
        return (p < floor_p) ? floor_p : p;
    endfunction

endpackage

// File: rtl/race_pulse_gen_pulse_line.sv
// pulse_line: one pulse train (period down-counter, PW shaper, edge counter).
//   clk, rst_n   - clock, async active-low reset
//   i_load       - transfer strobe: latch i_period, clear counters
//   i_period     - clamped period in cycles (>= PW+1)
//   i_run        - counter advances only while high
//   i_fire_en    - gate for the rising edge (loser suppression)
//   o_armed      - counter at 0 while running (edge would fire if enabled)
//   o_edge       - rising edge fires this cycle (pulse high after the edge)
//   o_busy_hi    - line stays high past the coming edge
//   o_pulse      - registered pulse output
//   o_edge_cnt   - rising edges emitted since load
module pulse_line
    import race_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int PW    = 2,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_period,
    input  logic             i_run,
    input  logic             i_fire_en,
    output logic             o_armed,
    output logic             o_edge,
    output logic             o_busy_hi,
    output logic             o_pulse,
    output logic [CW-1:0]    o_edge_cnt
);

    localparam int HW = bits_for(PW);

    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_cnt;
    logic [HW-1:0]    r_hi_cnt;
    logic             r_pulse;
    logic [CW-1:0]    r_edge_cnt;
    logic             w_armed;
    logic             w_fire;

    assign w_armed = i_run && (r_cnt == '0);
    assign w_fire  = w_armed && i_fire_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period   <= '0;
            r_cnt      <= '0;
            r_hi_cnt   <= '0;
            r_pulse    <= 1'b0;
            r_edge_cnt <= '0;
        end else if (i_load) begin
            r_period   <= i_period;
            r_cnt      <= i_period - CNT_W'(1);
            r_hi_cnt   <= '0;
            r_pulse    <= 1'b0;
            r_edge_cnt <= '0;
        end else begin
            // A suppressed edge still reloads; the loser is dead after that anyway.
            if (i_run)
                r_cnt <= (r_cnt == '0) ? r_period - CNT_W'(1) : r_cnt - CNT_W'(1);
            if (w_fire) begin
                r_pulse    <= 1'b1;
                r_hi_cnt   <= HW'(PW - 1);
                r_edge_cnt <= r_edge_cnt + CW'(1);
            end else if (r_pulse) begin
                if (r_hi_cnt == '0)
                    r_pulse <= 1'b0;
                else
                    r_hi_cnt <= r_hi_cnt - HW'(1);
            end
        end
    end

    assign o_armed    = w_armed;
    assign o_edge     = w_fire;
    assign o_busy_hi  = r_pulse && (r_hi_cnt != '0);
    assign o_pulse    = r_pulse;
    assign o_edge_cnt = r_edge_cnt;

endmodule

// File: rtl/race_pulse_gen.sv
// race_pulse_gen: encodes one bit per symbol as a race between two pulse
// trains; the winner emits exactly N rising edges, the loser at most N-1.
//   clk, rst_n          - clock, async active-low reset
//   in_valid/in_ready   - symbol handshake (ready only in IDLE)
//   in_bit              - 1: A wins, 0: B wins
//   period_fast/_slow   - winner/loser periods, sampled at transfer
//   pulse_a, pulse_b    - registered pulse trains to the comparators
//   busy                - symbol in progress
//   sym_done            - one-cycle end-of-symbol strobe
module race_pulse_gen
    import race_pkg::*;
#(
    parameter int N     = RACE_N,
    parameter int CNT_W = 16,
    parameter int PW    = 2,
    parameter int GAP   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic [CNT_W-1:0] period_fast,
    input  logic [CNT_W-1:0] period_slow,
    output logic             pulse_a,
    output logic             pulse_b,
    output logic             busy,
    output logic             sym_done
);

    localparam int CW = edge_cnt_w(N);
    localparam int GW = bits_for(GAP);

    race_state_t      r_state, w_state_nxt;
    logic             r_bit;
    logic             r_busy;
    logic             r_sym_done;
    logic [GW-1:0]    r_gap_cnt;

    logic             w_xfer, w_run, w_gap_last;
    logic [CNT_W-1:0] w_pf_cl, w_ps_cl, w_per_a, w_per_b;
    logic             w_arm_a, w_arm_b, w_edge_a, w_edge_b;
    logic             w_bhi_a, w_bhi_b, w_pulse_a, w_pulse_b;
    logic [CW-1:0]    w_cnt_a, w_cnt_b, w_win_cnt;
    logic             w_win_at_last, w_win_armed, w_win_edge, w_win_last;
    logic             w_kill, w_en_a, w_en_b;

    assign in_ready = rst_n && (r_state == S_IDLE);
    assign w_xfer   = in_valid && in_ready;
    assign w_run    = (r_state == S_RUN);

    // Periods wider than 32 bits would be truncated by the clamp helper.
    assign w_pf_cl = CNT_W'(clamp_period(32'(period_fast), PW));
    assign w_ps_cl = CNT_W'(clamp_period(32'(period_slow), PW));
    assign w_per_a = in_bit ? w_pf_cl : w_ps_cl;
    assign w_per_b = in_bit ? w_ps_cl : w_pf_cl;

    assign w_win_cnt     = r_bit ? w_cnt_a  : w_cnt_b;
    assign w_win_armed   = r_bit ? w_arm_a  : w_arm_b;
    assign w_win_edge    = r_bit ? w_edge_a : w_edge_b;
    assign w_win_at_last = (w_win_cnt == CW'(N - 1));
    assign w_win_last    = w_win_edge && w_win_at_last;

    // Loser kill derives from the winner's ungated arm signal (the winner is
    // never gated), which keeps the enables free of combinational loops.
    assign w_kill = w_win_armed && w_win_at_last;
    assign w_en_a = r_bit  || !w_kill;
    assign w_en_b = !r_bit || !w_kill;

    pulse_line #(.CNT_W(CNT_W), .PW(PW), .CW(CW)) u_line_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_xfer),
        .i_period   (w_per_a),
        .i_run      (w_run),
        .i_fire_en  (w_en_a),
        .o_armed    (w_arm_a),
        .o_edge     (w_edge_a),
        .o_busy_hi  (w_bhi_a),
        .o_pulse    (w_pulse_a),
        .o_edge_cnt (w_cnt_a)
    );

    pulse_line #(.CNT_W(CNT_W), .PW(PW), .CW(CW)) u_line_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_xfer),
        .i_period   (w_per_b),
        .i_run      (w_run),
        .i_fire_en  (w_en_b),
        .o_armed    (w_arm_b),
        .o_edge     (w_edge_b),
        .o_busy_hi  (w_bhi_b),
        .o_pulse    (w_pulse_b),
        .o_edge_cnt (w_cnt_b)
    );

    assign w_gap_last = (r_state == S_GAP) && (r_gap_cnt == GW'(GAP - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_xfer)     w_state_nxt = S_RUN;
            S_RUN:  if (w_win_last) w_state_nxt = S_TAIL;
            // Leave when both lines will be low after this edge, so that low
            // cycle already counts as the first GAP cycle.
            S_TAIL: if (!w_bhi_a && !w_bhi_b) w_state_nxt = S_GAP;
            S_GAP:  if (w_gap_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit      <= 1'b0;
            r_busy     <= 1'b0;
            r_sym_done <= 1'b0;
            r_gap_cnt  <= '0;
        end else begin
            if (w_xfer)
                r_bit <= in_bit;
            if (w_xfer)
                r_busy <= 1'b1;
            else if (w_gap_last)
                r_busy <= 1'b0;
            r_sym_done <= w_gap_last;
            if (r_state != S_GAP)
                r_gap_cnt <= '0;
            else
                r_gap_cnt <= r_gap_cnt + GW'(1);
        end
    end

    assign pulse_a  = w_pulse_a;
    assign pulse_b  = w_pulse_b;
    assign busy     = r_busy;
    assign sym_done = r_sym_done;

endmodule

// File: tb/tb_race_pulse_gen.sv
// tb_race_pulse_gen: directed symbols checked every cycle against a model
// built from edge times k*P, plus literal edge counts / done cycles.
module tb_race_pulse_gen;

    localparam int N     = 10;
    localparam int CNT_W = 16;
    localparam int PW    = 2;
    localparam int GAP   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_bit = 1'b0;
    logic [CNT_W-1:0] period_fast = '0;
    logic [CNT_W-1:0] period_slow = '0;
    logic             pulse_a, pulse_b, busy, sym_done;

    race_pulse_gen #(.N(N), .CNT_W(CNT_W), .PW(PW), .GAP(GAP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bit      (in_bit),
        .period_fast (period_fast),
        .period_slow (period_slow),
        .pulse_a     (pulse_a),
        .pulse_b     (pulse_b),
        .busy        (busy),
        .sym_done    (sym_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic int pcl(input int p);
        return (p < PW + 1) ? PW + 1 : p;
    endfunction

    // Loser edges are those at k*ps strictly before the winner's last edge.
    function automatic int loser_n(input int pf, input int ps);
        int n = 0;
        for (int k = 1; k <= N; k++)
            if (k * ps < N * pf) n++;
        return (n > N - 1) ? N - 1 : n;
    endfunction

    function automatic int line_hi(input int c, input int p, input int n);
        for (int k = 1; k <= n; k++)
            if (k * p <= c && c < k * p + PW) return 1;
        return 0;
    endfunction

    bit m_active = 0;
    bit m_bit;
    int m_pf, m_ps, m_ln, m_sd, m_t0;

    // observations made by the compare process, per symbol
    int obs_a, obs_b, obs_sd;
    int cc, ea, eb;
    logic pa, pb;

    always @(posedge clk) begin
        #1;
        if (m_active) begin
            cc = cyc - m_t0;
            if (cc == 0) begin
                obs_a = 0; obs_b = 0; obs_sd = -1; pa = 1'b0; pb = 1'b0;
            end
            ea = m_bit ? line_hi(cc, m_pf, N) : line_hi(cc, m_ps, m_ln);
            eb = m_bit ? line_hi(cc, m_ps, m_ln) : line_hi(cc, m_pf, N);
            chk("pulse_a", 32'(pulse_a), 32'(ea));
            chk("pulse_b", 32'(pulse_b), 32'(eb));
            chk("busy", 32'(busy), 32'(cc < m_sd));
            chk("sym_done", 32'(sym_done), 32'(cc == m_sd));
            chk("in_ready", 32'(in_ready), 32'(cc == m_sd));
            if (pulse_a && !pa) obs_a++;
            if (pulse_b && !pb) obs_b++;
            if (sym_done) obs_sd = cc;
            pa = pulse_a;
            pb = pulse_b;
            if (cc >= m_sd) m_active = 0;
        end
    end

    // Call at a negedge; the transfer happens at the following posedge.
    task automatic start_sym(input bit b, input int pf, input int ps, input bit hold);
        int tail;
        in_valid    = 1'b1;
        in_bit      = b;
        period_fast = CNT_W'(pf);
        period_slow = CNT_W'(ps);
        m_bit = b;
        m_pf  = pcl(pf);
        m_ps  = pcl(ps);
        m_ln  = loser_n(m_pf, m_ps);
        tail  = N * m_pf + PW;
        if (m_ln > 0 && m_ln * m_ps + PW > tail) tail = m_ln * m_ps + PW;
        m_sd  = tail + GAP;
        m_t0  = cyc + 1;
        m_active = 1;
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    // Returns at the negedge right after the model's sym_done cycle.
    task automatic wait_done();
        for (int i = 0; i < 3000 && m_active; i++) @(negedge clk);
        if (m_active) begin
            total++; bad++;
            $display("FAIL timeout waiting for sym_done");
            m_active = 0;
        end
    endtask

    task automatic pin(input string nm, input int a, input int b, input int sd);
        chk({nm, "_a_edges"}, 32'(obs_a), 32'(a));
        chk({nm, "_b_edges"}, 32'(obs_b), 32'(b));
        chk({nm, "_done_cycle"}, 32'(obs_sd), 32'(sd));
    endtask

    initial begin
        int dec;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_pulse_a", 32'(pulse_a), 32'd0);
        chk("rst_pulse_b", 32'(pulse_b), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sym_done", 32'(sym_done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // bit 1, A wins
        start_sym(1'b1, 4, 7, 1'b0);
        wait_done();
        pin("s1", 10, 5, 46);

        // bit 0, tie at 30 suppressed
        start_sym(1'b0, 3, 5, 1'b0);
        wait_done();
        pin("s2", 5, 10, 36);

        // equal periods: loser stops at 9, receiver decodes 1
        start_sym(1'b1, 6, 6, 1'b0);
        wait_done();
        pin("s3", 10, 9, 66);
        dec = (obs_a >= N && obs_b < N) ? 1 : 0;
        chk("s3_decoded_bit", 32'(dec), 32'd1);

        // clamp: both periods become 3
        start_sym(1'b1, 1, 0, 1'b0);
        wait_done();
        pin("s4", 10, 9, 36);

        // reset mid-RUN after the 4th A edge
        start_sym(1'b1, 4, 7, 1'b0);
        for (int i = 0; i < 200 && obs_a < 4; i++) @(negedge clk);
        chk("s5_pre_rst_a_edges", 32'(obs_a), 32'd4);
        m_active = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("s5_rst_pulse_a", 32'(pulse_a), 32'd0);
        chk("s5_rst_pulse_b", 32'(pulse_b), 32'd0);
        chk("s5_rst_busy", 32'(busy), 32'd0);
        chk("s5_rst_in_ready", 32'(in_ready), 32'd0);
        chk("s5_rst_sym_done", 32'(sym_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("s5_rel_in_ready", 32'(in_ready), 32'd1);
        chk("s5_rel_busy", 32'(busy), 32'd0);
        chk("s5_rel_pulse_a", 32'(pulse_a), 32'd0);
        @(negedge clk);
        start_sym(1'b0, 5, 9, 1'b0);
        wait_done();
        pin("s5", 5, 10, 56);

        // back-to-back with in_valid held; second bit offered while busy
        start_sym(1'b1, 4, 7, 1'b1);
        in_bit = 1'b0;
        wait_done();
        pin("s6a", 10, 5, 46);
        start_sym(1'b0, 4, 7, 1'b0);
        wait_done();
        pin("s6b", 5, 10, 46);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/race_pulse_gen.md
# race_pulse_gen

Transmit-side counterpart of the comparator race counter. It encodes one bit per symbol as two pulse trains, `pulse_a` and `pulse_b`. The "winning" line reaches exactly N rising edges first, and the losing line never reaches N, so a downstream race counter with the same N decodes the bit. It sits between the digital test/stimulus logic and the two comparator inputs of the receiver, and is used for self-test and link bring-up.

## Interface
- `N`, default 10: rising edges emitted on the winning line per symbol; must equal the receiver threshold.
- `CNT_W`, default 16: width of the period inputs and period counters.
- `PW`, default 2: pulse high time in clk cycles, ≥1.
- `GAP`, default 4: idle cycles (both lines low) after each symbol, ≥1.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: a symbol is offered.
- `in_ready`, out, 1: high only in IDLE; a transfer occurs when `in_valid && in_ready` at a clk edge.
- `in_bit`, in, 1: 1 makes A the winner (receiver outputs 1); 0 makes B the winner.
- `period_fast`, in, CNT_W: winner pulse period in cycles; sampled at transfer.
- `period_slow`, in, CNT_W: loser pulse period in cycles; sampled at transfer.
- `pulse_a`, out, 1: registered pulse train to comparator_1.
- `pulse_b`, out, 1: registered pulse train to comparator_2.
- `busy`, out, 1: high from the cycle after transfer until `sym_done`.
- `sym_done`, out, 1: one-cycle strobe at end of symbol.

## Operation
- FSM states: IDLE → RUN → TAIL → GAP → IDLE.
- IDLE: `in_ready`=1. On transfer, latch `in_bit` and both periods, clear the counters, and go to RUN.
- Period clamp: any latched period < PW+1 is replaced by PW+1, which guarantees at least one low cycle between pulses.
- Each line has a down-counter loaded with period−1. A rising edge fires when the counter reaches 0 (then it reloads), and the line stays high for PW cycles.
- Winner pulse count: `$clog2(N+1)` bits. Its Nth rising edge moves the FSM to TAIL.
- Loser suppression: any loser rising edge in the same cycle as, or after, the winner's Nth edge is suppressed. The loser therefore always emits ≤ N−1 edges, including when the periods are equal.
- An already-high loser pulse completes its PW cycles in TAIL and is not truncated.
- TAIL: wait until both lines are low, then go to GAP.
- GAP: count GAP cycles with both lines low. On the last one, assert `sym_done`, deassert `busy`, and go to IDLE.
- `in_valid` is ignored outside IDLE. Latched inputs are frozen for the whole symbol.
- Reset mid-operation: all outputs go to 0 immediately and the FSM returns to IDLE. `in_ready`=1 on the first edge after release, and no partial symbol resumes.
- Reset values: `pulse_a`=`pulse_b`=`busy`=`sym_done`=0, `in_ready`=1 once out of reset (0 while `rst_n` is low).

## Timing
- Cycle 0 is the transfer edge. Winner rising edges are at cycles k·Pf for k=1..N, with Pf the clamped fast period.
- Loser rising edges are at k·Ps for all k·Ps < N·Pf, so the loser count is min(ceil(N·Pf/Ps)−1, N−1).
- TAIL ends when both lines are low. For the winner that is cycle N·Pf+PW. If a loser pulse is still high, TAIL ends later.
- `sym_done` is high at cycle N·Pf+PW+GAP when nothing extends TAIL.
- `in_ready` rises in the same cycle as `sym_done`. A back-to-back transfer can occur at that cycle's following edge.

## Structure
- Package `race_pkg`:
  - state enum `race_state_t`;
  - count-width localparam derived from N;
  - period clamp helper function.
- Sub-module `pulse_line`, instantiated twice:
  - period down-counter, PW pulse shaper and edge counter;
  - `fire_en` input for suppression;
  - `edge` and `busy_hi` outputs.
- The top level holds the FSM, input latch, winner/loser routing and GAP counter.

## Test plan
All scenarios use N=10, PW=2, GAP=4.
- **Bit 1, A wins:** `in_bit`=1, Pf=4, Ps=7 → A edges at 4,8,…,40 (10 edges); B edges at 7,14,21,28,35 (5 edges); `sym_done` at cycle 46.
- **Bit 0, tie suppressed:** `in_bit`=0, Pf=3, Ps=5 → B 10 edges ending at cycle 30; A edges at 5–25 (5 edges), with the tie at 30 suppressed; `sym_done` at cycle 36.
- **Equal periods:** `in_bit`=1, Pf=Ps=6 → A 10 edges, B exactly 9 edges; a model of the receiver decodes 1.
- **Period clamp:** Pf=1, Ps=0 → both periods treated as 3; A edges every 3 cycles; B 9 edges; every pulse 2 cycles high with ≥1 low cycle between.
- **Reset mid-RUN:** assert `rst_n` low after the 4th A edge → both lines and `busy` go to 0 asynchronously; `in_ready`=1 after release; the next symbol again produces exactly 10 winner edges.
- **Back-to-back:** hold `in_valid`=1 with bits 1 then 0 → second transfer at the edge after `sym_done`; winners swap and `in_valid` is ignored while `busy`.
